// File: rtl/rs_alu_issue.sv
// ALU reservation station: holds dispatched ops until both operands are valid,
// snoops the writeback bus for wakeups and issues the lowest ready entry each cycle.
module rs_alu_issue #(
  parameter int ENTNUM          = 4,
  parameter int ADDR_LEN        = 32,
  parameter int DATA_LEN        = 32,
  parameter int RRF_SEL         = 6,
  parameter int SRC_A_SEL_WIDTH = 2,
  parameter int SRC_B_SEL_WIDTH = 2,
  parameter int ALU_OP_WIDTH    = 4,
  parameter int SPECTAG_LEN     = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [ADDR_LEN-1:0]        wpc,
  input  logic [DATA_LEN-1:0]        wimm,
  input  logic [DATA_LEN-1:0]        wsrc1,
  input  logic [DATA_LEN-1:0]        wsrc2,
  input  logic                       wvalid1,
  input  logic                       wvalid2,
  input  logic [RRF_SEL-1:0]         wrrftag,
  input  logic                       wdstval,
  input  logic [SRC_A_SEL_WIDTH-1:0] wsrc_a,
  input  logic [SRC_B_SEL_WIDTH-1:0] wsrc_b,
  input  logic [ALU_OP_WIDTH-1:0]    walu_op,
  input  logic [SPECTAG_LEN-1:0]     wspectag,
  input  logic                       wspecbit,
  input  logic                       wb_we,
  input  logic [RRF_SEL-1:0]         wb_rrftag,
  input  logic [DATA_LEN-1:0]        wb_data,
  input  logic                       prmiss,
  input  logic                       prsuccess,
  input  logic [SPECTAG_LEN-1:0]     spectagfix,
  output logic                       issue,
  output logic [DATA_LEN-1:0]        ex_src1,
  output logic [DATA_LEN-1:0]        ex_src2,
  output logic [ADDR_LEN-1:0]        pc,
  output logic [DATA_LEN-1:0]        imm,
  output logic                       dstval,
  output logic [SRC_A_SEL_WIDTH-1:0] src_a,
  output logic [SRC_B_SEL_WIDTH-1:0] src_b,
  output logic [ALU_OP_WIDTH-1:0]    alu_op,
  output logic [SPECTAG_LEN-1:0]     spectag,
  output logic                       specbit,
  output logic [RRF_SEL-1:0]         rrftag,
  output logic                       full,
  output logic [$clog2(ENTNUM):0]    count
);
  localparam int IDX_W = $clog2(ENTNUM);

  logic [ENTNUM-1:0]          r_valid, r_v1, r_v2, r_dstval, r_specbit;
  logic [DATA_LEN-1:0]        r_src1 [ENTNUM];
  logic [DATA_LEN-1:0]        r_src2 [ENTNUM];
  logic [DATA_LEN-1:0]        r_imm [ENTNUM];
  logic [ADDR_LEN-1:0]        r_pc [ENTNUM];
  logic [RRF_SEL-1:0]         r_rrftag [ENTNUM];
  logic [SRC_A_SEL_WIDTH-1:0] r_src_a [ENTNUM];
  logic [SRC_B_SEL_WIDTH-1:0] r_src_b [ENTNUM];
  logic [ALU_OP_WIDTH-1:0]    r_alu_op [ENTNUM];
  logic [SPECTAG_LEN-1:0]     r_spectag [ENTNUM];

  logic [ENTNUM-1:0]      w_kill, w_ready;
  logic [IDX_W-1:0]       w_sel, w_free;
  logic                   w_any, w_wkill, w_write, w_mask, w_wb1, w_wb2;
  logic [IDX_W:0]         w_count;
  logic [SPECTAG_LEN-1:0] w_wspectag;

  // Issue contract: issue=1 means the ex_* fields carry the selected entry this
  // cycle; the execution unit always accepts, so the entry is freed at the edge.
  always_comb begin
    w_kill  = '0;
    w_ready = '0;
    w_count = '0;
    for (int i = 0; i < ENTNUM; i++) begin
      w_kill[i]  = prmiss & r_specbit[i] & (|(r_spectag[i] & spectagfix));
      w_ready[i] = r_valid[i] & r_v1[i] & r_v2[i] & ~w_kill[i];
      w_count    = w_count + {{IDX_W{1'b0}}, r_valid[i]};
    end
  end

  // Scan downward so the lowest index wins for both issue and allocation.
  always_comb begin
    w_sel  = '0;
    w_any  = 1'b0;
    w_free = '0;
    for (int i = ENTNUM - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel = IDX_W'(i);
        w_any = 1'b1;
      end
      if (!r_valid[i]) w_free = IDX_W'(i);
    end
  end

  assign count      = w_count;
  assign full       = (w_count == (IDX_W+1)'(ENTNUM));
  assign w_wkill    = prmiss & wspecbit & (|(wspectag & spectagfix));
  assign w_write    = we & ~full & ~w_wkill;
  assign w_mask     = prsuccess & ~prmiss;
  assign w_wb1      = wb_we & ~wvalid1 & (wsrc1[RRF_SEL-1:0] == wb_rrftag);
  assign w_wb2      = wb_we & ~wvalid2 & (wsrc2[RRF_SEL-1:0] == wb_rrftag);
  assign w_wspectag = w_mask ? (wspectag & ~spectagfix) : wspectag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < ENTNUM; i++) begin
        if (w_write && (w_free == IDX_W'(i))) r_valid[i] <= 1'b1;
        else if ((w_any && (w_sel == IDX_W'(i))) || w_kill[i]) r_valid[i] <= 1'b0;
      end
    end
  end

  // Payload needs no reset: r_valid gates every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTNUM; i++) begin
      if (w_write && (w_free == IDX_W'(i))) begin
        r_v1[i]      <= wvalid1 | w_wb1;
        r_v2[i]      <= wvalid2 | w_wb2;
        r_src1[i]    <= w_wb1 ? wb_data : wsrc1;
        r_src2[i]    <= w_wb2 ? wb_data : wsrc2;
        r_imm[i]     <= wimm;
        r_pc[i]      <= wpc;
        r_rrftag[i]  <= wrrftag;
        r_dstval[i]  <= wdstval;
        r_src_a[i]   <= wsrc_a;
        r_src_b[i]   <= wsrc_b;
        r_alu_op[i]  <= walu_op;
        r_spectag[i] <= w_wspectag;
        r_specbit[i] <= wspecbit;
      end else begin
        if (wb_we && !r_v1[i] && (r_src1[i][RRF_SEL-1:0] == wb_rrftag)) begin
          r_src1[i] <= wb_data;
          r_v1[i]   <= 1'b1;
        end
        if (wb_we && !r_v2[i] && (r_src2[i][RRF_SEL-1:0] == wb_rrftag)) begin
          r_src2[i] <= wb_data;
          r_v2[i]   <= 1'b1;
        end
        if (w_mask) r_spectag[i] <= r_spectag[i] & ~spectagfix;
      end
    end
  end

  assign issue   = w_any;
  assign ex_src1 = r_src1[w_sel];
  assign ex_src2 = r_src2[w_sel];
  assign pc      = r_pc[w_sel];
  assign imm     = r_imm[w_sel];
  assign dstval  = r_dstval[w_sel];
  assign src_a   = r_src_a[w_sel];
  assign src_b   = r_src_b[w_sel];
  assign alu_op  = r_alu_op[w_sel];
  assign spectag = r_spectag[w_sel];
  assign specbit = r_specbit[w_sel];
  assign rrftag  = r_rrftag[w_sel];

endmodule

// File: tb/tb_rs_alu_issue.sv
// Bench for rs_alu_issue: directed scenarios plus random traffic, checked by a
// slot-level reference model feeding an expected-issue queue.
module tb_rs_alu_issue;
  localparam int N  = 4;
  localparam int AL = 32;
  localparam int DL = 32;
  localparam int RS = 6;
  localparam int SA = 2;
  localparam int SB = 2;
  localparam int OP = 4;
  localparam int ST = 5;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 3*DL + AL + 1 + SA + SB + OP + ST + 1 + RS;
  localparam logic [OP-1:0] ALU_ADD = '0;

  logic          clk, reset, we, wvalid1, wvalid2, wdstval, wspecbit;
  logic [AL-1:0] wpc;
  logic [DL-1:0] wimm, wsrc1, wsrc2, wb_data;
  logic [RS-1:0] wrrftag, wb_rrftag;
  logic [SA-1:0] wsrc_a;
  logic [SB-1:0] wsrc_b;
  logic [OP-1:0] walu_op;
  logic [ST-1:0] wspectag, spectagfix;
  logic          wb_we, prmiss, prsuccess;
  logic          issue, dstval, specbit, full;
  logic [DL-1:0] ex_src1, ex_src2, imm;
  logic [AL-1:0] pc;
  logic [SA-1:0] src_a;
  logic [SB-1:0] src_b;
  logic [OP-1:0] alu_op;
  logic [ST-1:0] spectag;
  logic [RS-1:0] rrftag;
  logic [CW-1:0] count;

  rs_alu_issue #(
    .ENTNUM(N), .ADDR_LEN(AL), .DATA_LEN(DL), .RRF_SEL(RS), .SRC_A_SEL_WIDTH(SA),
    .SRC_B_SEL_WIDTH(SB), .ALU_OP_WIDTH(OP), .SPECTAG_LEN(ST)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .wpc(wpc), .wimm(wimm), .wsrc1(wsrc1),
    .wsrc2(wsrc2), .wvalid1(wvalid1), .wvalid2(wvalid2), .wrrftag(wrrftag),
    .wdstval(wdstval), .wsrc_a(wsrc_a), .wsrc_b(wsrc_b), .walu_op(walu_op),
    .wspectag(wspectag), .wspecbit(wspecbit), .wb_we(wb_we), .wb_rrftag(wb_rrftag),
    .wb_data(wb_data), .prmiss(prmiss), .prsuccess(prsuccess), .spectagfix(spectagfix),
    .issue(issue), .ex_src1(ex_src1), .ex_src2(ex_src2), .pc(pc), .imm(imm),
    .dstval(dstval), .src_a(src_a), .src_b(src_b), .alu_op(alu_op), .spectag(spectag),
    .specbit(specbit), .rrftag(rrftag), .full(full), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit            valid, v1, v2, dstval, sbit;
    logic [DL-1:0] src1, src2, imm;
    logic [AL-1:0] pc;
    logic [SA-1:0] sa;
    logic [SB-1:0] sb;
    logic [OP-1:0] op;
    logic [ST-1:0] tag;
    logic [RS-1:0] rrf;
  } ent_t;

  ent_t m [N];
  bit   m_kill [N];
  int   m_sel, m_free, m_cnt;
  logic [PW-1:0] exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [PW-1:0] pack_ent(ent_t e);
    return {e.src1, e.src2, e.pc, e.imm, e.dstval, e.sa, e.sb, e.op, e.tag, e.sbit, e.rrf};
  endfunction

  // Writeback snoop and branch-success masking, applied to any surviving or new entry.
  function automatic ent_t wake(ent_t e);
    ent_t r = e;
    if (wb_we && !r.v1 && r.src1[RS-1:0] == wb_rrftag) begin r.src1 = wb_data; r.v1 = 1; end
    if (wb_we && !r.v2 && r.src2[RS-1:0] == wb_rrftag) begin r.src2 = wb_data; r.v2 = 1; end
    if (prsuccess && !prmiss) r.tag = r.tag & ~spectagfix;
    return r;
  endfunction

  task automatic model_eval();
    m_sel = -1; m_free = -1; m_cnt = 0;
    for (int i = N - 1; i >= 0; i--) begin
      m_kill[i] = prmiss && m[i].sbit && ((m[i].tag & spectagfix) != 0);
      if (m[i].valid) m_cnt++; else m_free = i;
      if (m[i].valid && m[i].v1 && m[i].v2 && !m_kill[i]) m_sel = i;
    end
    if (!reset && m_sel >= 0) exp_q.push_back(pack_ent(m[m_sel]));
  endtask

  task automatic model_update();
    ent_t e;
    if (reset) begin
      for (int i = 0; i < N; i++) m[i].valid = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].valid) begin
        if (i == m_sel || m_kill[i]) m[i].valid = 0;
        else m[i] = wake(m[i]);
      end
    end
    if (we && m_cnt < N && !(prmiss && wspecbit && ((wspectag & spectagfix) != 0))) begin
      e.valid = 1; e.v1 = wvalid1; e.v2 = wvalid2; e.src1 = wsrc1; e.src2 = wsrc2;
      e.imm = wimm; e.pc = wpc; e.dstval = wdstval; e.sa = wsrc_a; e.sb = wsrc_b;
      e.op = walu_op; e.tag = wspectag; e.sbit = wspecbit; e.rrf = wrrftag;
      m[m_free] = wake(e);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [PW-1:0] got, expv;
    if (!reset) begin
      if (issue) begin
        got = {ex_src1, ex_src2, pc, imm, dstval, src_a, src_b, alu_op, spectag, specbit, rrftag};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_issue got=%0h exp=no_issue", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin
            n_errors++;
            $display("FAIL issue_payload got=%0h exp=%0h", got, expv);
          end
        end
      end else if (exp_q.size() != 0) begin
        n_checks++;
        n_errors++;
        expv = exp_q.pop_front();
        $display("FAIL missing_issue got=no_issue exp=%0h", expv);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  task automatic set_idle();
    reset = 0; we = 0; wvalid1 = 0; wvalid2 = 0; wsrc1 = '0; wsrc2 = '0; wpc = '0;
    wimm = '0; wrrftag = '0; wdstval = 0; wsrc_a = '0; wsrc_b = '0; walu_op = '0;
    wspectag = '0; wspecbit = 0; wb_we = 0; wb_rrftag = '0; wb_data = '0;
    prmiss = 0; prsuccess = 0; spectagfix = '0;
  endtask

  task automatic step();
    model_eval();
    @(negedge clk);
    if (!reset) begin
      chk("count", 32'(count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == N));
    end
    model_update();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic dispatch(bit v1, logic [DL-1:0] s1, bit v2, logic [DL-1:0] s2,
                          logic [ST-1:0] tag, bit sbit, logic [OP-1:0] op);
    we = 1; wvalid1 = v1; wsrc1 = s1; wvalid2 = v2; wsrc2 = s2;
    wspectag = tag; wspecbit = sbit; walu_op = op;
    wpc = $urandom; wimm = $urandom; wdstval = 1'($urandom_range(0, 1));
    wsrc_a = SA'($urandom_range(0, 3)); wsrc_b = SB'($urandom_range(0, 3));
    wrrftag = RS'($urandom_range(0, 63));
  endtask

  task automatic wakeup(logic [RS-1:0] tag, logic [DL-1:0] data);
    wb_we = 1; wb_rrftag = tag; wb_data = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) m[i].valid = 0;
    set_idle();
    reset = 1;
    step();
    reset = 1;
    step();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_issue", 32'(issue), 32'd0);

    // Ready-at-dispatch ADD issues the next cycle, then the station drains.
    dispatch(1, 32'd5, 1, 32'd7, '0, 0, ALU_ADD);
    step(); step(); step();

    // Operand 2 waits on tag 3; wakeup three cycles later.
    dispatch(1, $urandom, 0, 32'd3, '0, 0, 4'd1);
    step(); step(); step();
    wakeup(6'd3, 32'h10);
    step(); step(); step();

    // Wakeup in the same cycle as dispatch must not be lost.
    dispatch(0, 32'd9, 1, $urandom, '0, 0, 4'd2);
    wakeup(6'd9, 32'hAA);
    step(); step();

    // Fill, overflow attempt, then release all at once.
    for (int i = 0; i <= N; i++) begin
      dispatch(1, $urandom, 0, 32'd1, '0, 0, OP'(i));
      step();
    end
    chk("fill_full", 32'(full), 32'd1);
    wakeup(6'd1, 32'h55);
    for (int i = 0; i < N + 2; i++) step();

    // Branch miss kills only tag-01 speculative entry; success clears tag 02.
    dispatch(1, $urandom, 0, 32'd7, 5'h01, 1, 4'd3); step();
    dispatch(1, $urandom, 0, 32'd7, 5'h02, 1, 4'd4); step();
    dispatch(1, $urandom, 0, 32'd7, 5'h00, 0, 4'd5); step();
    prmiss = 1; spectagfix = 5'h01; step();
    chk("kill_count", 32'(count), 32'd2);
    prsuccess = 1; spectagfix = 5'h02; step();
    wakeup(6'd7, 32'h77);
    step(); step(); step(); step();

    // Reset with pending entries and concurrent write/wakeup.
    for (int i = 0; i < 3; i++) begin
      dispatch(1, $urandom, 0, 32'd5, '0, 0, 4'd6);
      step();
    end
    reset = 1;
    dispatch(1, $urandom, 1, $urandom, '0, 0, 4'd7);
    wakeup(6'd5, 32'h99);
    step();
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_issue", 32'(issue), 32'd0);
    wakeup(6'd5, 32'h99);
    step(); step(); step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        bit v1, v2;
        v1 = 1'($urandom_range(0, 1));
        v2 = 1'($urandom_range(0, 1));
        dispatch(v1, v1 ? DL'($urandom) : DL'($urandom_range(0, 7)),
                 v2, v2 ? DL'($urandom) : DL'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1) ? ST'(1 << $urandom_range(0, ST - 1)) : '0,
                 1'($urandom_range(0, 1)), OP'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 1) == 1) wakeup(RS'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 15) == 0) prmiss = 1;
      if ($urandom_range(0, 7) == 0) prsuccess = 1;
      spectagfix = ST'(1 << $urandom_range(0, ST - 1));
      if ($urandom_range(0, 199) == 0) reset = 1;
      step();
    end

    for (int i = 0; i < 6; i++) step();
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
